// File: rtl/regfile_writeback_sink_if.sv
// Writeback/decode bus for the integer register file.
// Carries the result bus, both read ports and the load scoreboard.
interface regfile_writeback_sink_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
);
    logic             RegWriteW;
    logic [AW-1:0]    RdW;
    logic [XLEN-1:0]  ResultW;
    logic [AW-1:0]    A1D;
    logic [AW-1:0]    A2D;
    logic [XLEN-1:0]  RD1D;
    logic [XLEN-1:0]  RD2D;
    logic             LoadIssueE;
    logic [AW-1:0]    RdE;
    logic             StallLoadD;
    logic [NREGS-1:0] BusyVec;

    modport master (
        output RegWriteW, RdW, ResultW,
        output A1D, A2D,
        output LoadIssueE, RdE,
        input  RD1D, RD2D,
        input  StallLoadD, BusyVec
    );

    modport slave (
        input  RegWriteW, RdW, ResultW,
        input  A1D, A2D,
        input  LoadIssueE, RdE,
        output RD1D, RD2D,
        output StallLoadD, BusyVec
    );
endinterface

// File: rtl/regfile_writeback_sink.sv
// Integer register file with write-through bypass and a
// per-register pending-load scoreboard driving a load-use stall.
module regfile_writeback_sink #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input logic                     clk,
    input logic                     rst,
    regfile_writeback_sink_if.slave bus
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr_en;
    logic             hit1;
    logic             hit2;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic             stall1;
    logic             stall2;

    assign wr_en = bus.RegWriteW && (bus.RdW != '0);

    // Architectural state; x0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.RdW] <= bus.ResultW;
        end
    end

    // Next scoreboard: a new load outranks the retiring writer.
    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < NREGS; i++) begin
            if (bus.LoadIssueE && bus.RdE == AW'(i)) begin
                busy_nxt[i] = 1'b1;
            end else if (wr_en && bus.RdW == AW'(i)) begin
                busy_nxt[i] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register; pending loads are dropped on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read ports with same-cycle bypass from writeback.
    always_comb begin
        hit1 = wr_en && (bus.RdW == bus.A1D);
        hit2 = wr_en && (bus.RdW == bus.A2D);
        rd1  = '0;
        rd2  = '0;
        if (bus.A1D != '0) begin
            rd1 = hit1 ? bus.ResultW : regs[bus.A1D];
        end
        if (bus.A2D != '0) begin
            rd2 = hit2 ? bus.ResultW : regs[bus.A2D];
        end
        if (!rst) begin
            rd1 = '0;
            rd2 = '0;
        end
    end

    // Stall while an operand awaits a load not landing now.
    always_comb begin
        stall1 = (bus.A1D != '0) && busy[bus.A1D] && !hit1;
        stall2 = (bus.A2D != '0) && busy[bus.A2D] && !hit2;
    end

    assign bus.RD1D       = rd1;
    assign bus.RD2D       = rd2;
    assign bus.StallLoadD = stall1 || stall2;
    assign bus.BusyVec    = busy;

endmodule

// File: tb/tb_regfile_writeback_sink.sv
// Randomized scoreboard bench for regfile_writeback_sink.
// Expected outputs come from an array model of the register file.
module tb_regfile_writeback_sink;

    logic clk;
    logic rst;

    regfile_writeback_sink_if #(.XLEN(32), .NREGS(32), .AW(5)) bus ();

    regfile_writeback_sink #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        stall;
        logic [31:0] busy;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_reg  [32];
    logic        m_busy [32];
    int          checks;
    int          errors;
    bit          done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mread(input logic [4:0] a,
                                          input logic we,
                                          input logic [4:0] rdw,
                                          input logic [31:0] res);
        if (a == 5'd0) return 32'd0;
        if (we && rdw == a) return res;
        return m_reg[a];
    endfunction

    // Apply one cycle of inputs; predict outputs; advance the model.
    task automatic cyc(input logic r, input logic we,
                       input logic [4:0] rdw, input logic [31:0] res,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic li, input logic [4:0] rde);
        exp_t e;
        @(negedge clk);
        rst            = r;
        bus.RegWriteW  = we;
        bus.RdW        = rdw;
        bus.ResultW    = res;
        bus.A1D        = a1;
        bus.A2D        = a2;
        bus.LoadIssueE = li;
        bus.RdE        = rde;
        if (!r) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = 32'd0;
                m_busy[i] = 1'b0;
            end
            e.rd1 = 32'd0;
            e.rd2 = 32'd0;
            e.stall = 1'b0;
            e.busy = 32'd0;
            q.push_back(e);
            return;
        end
        e.rd1 = mread(a1, we, rdw, res);
        e.rd2 = mread(a2, we, rdw, res);
        e.stall = 1'b0;
        if (a1 != 0 && m_busy[a1] && !(we && rdw == a1)) e.stall = 1'b1;
        if (a2 != 0 && m_busy[a2] && !(we && rdw == a2)) e.stall = 1'b1;
        for (int i = 0; i < 32; i++) e.busy[i] = m_busy[i];
        q.push_back(e);
        if (we && rdw != 0) begin
            m_reg[rdw]  = res;
            m_busy[rdw] = 1'b0;
        end
        if (li && rde != 0) m_busy[rde] = 1'b1;
    endtask

    // Monitor: compare live outputs against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        #2;
        while (q.size() > 0) begin
            e = q.pop_front();
            checks += 4;
            if (bus.RD1D !== e.rd1) begin
                errors++;
                $display("FAIL rd1 got %h exp %h t=%0t",
                         bus.RD1D, e.rd1, $time);
            end
            if (bus.RD2D !== e.rd2) begin
                errors++;
                $display("FAIL rd2 got %h exp %h t=%0t",
                         bus.RD2D, e.rd2, $time);
            end
            if (bus.StallLoadD !== e.stall) begin
                errors++;
                $display("FAIL stall got %b exp %b t=%0t",
                         bus.StallLoadD, e.stall, $time);
            end
            if (bus.BusyVec !== e.busy) begin
                errors++;
                $display("FAIL busy got %h exp %h t=%0t",
                         bus.BusyVec, e.busy, $time);
            end
        end
    end

    initial begin
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic [4:0]  rl;
        checks = 0;
        errors = 0;
        done   = 1'b0;
        rst    = 1'b0;
        bus.RegWriteW  = 1'b0;
        bus.RdW        = '0;
        bus.ResultW    = '0;
        bus.A1D        = '0;
        bus.A2D        = '0;
        bus.LoadIssueE = 1'b0;
        bus.RdE        = '0;
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end

        cyc(0, 0, 0, 0, 5, 31, 0, 0);
        cyc(1, 0, 0, 0, 5, 31, 0, 0);

        cyc(1, 1, 7, 32'hDEADBEEF, 7, 0, 0, 0);
        cyc(1, 0, 0, 0, 7, 7, 0, 0);

        cyc(1, 1, 0, 32'h12345678, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);

        cyc(1, 0, 0, 0, 0, 0, 1, 3);
        cyc(1, 0, 0, 0, 0, 3, 0, 0);
        cyc(1, 1, 3, 32'hA5A5A5A5, 0, 3, 0, 0);
        cyc(1, 0, 0, 0, 3, 3, 0, 0);

        cyc(1, 0, 0, 0, 0, 0, 1, 9);
        cyc(1, 1, 9, 32'h0BADF00D, 9, 0, 1, 9);
        cyc(1, 0, 0, 0, 9, 9, 0, 0);

        cyc(1, 1, 4, 32'h55, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 4, 0, 1, 4);
        cyc(1, 0, 0, 0, 4, 4, 0, 0);
        cyc(0, 0, 0, 0, 4, 4, 0, 0);
        cyc(1, 0, 0, 0, 4, 4, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rw = 5'($urandom_range(0, 7));
            rl = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ra = 5'($urandom);
            if ($urandom_range(0, 3) == 0) rw = 5'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                cyc(0, 0, 0, 0, ra, rb, 0, 0);
            end else begin
                cyc(1, 1'($urandom), rw, $urandom, ra, rb,
                    ($urandom_range(0, 2) == 0), rl);
            end
        end

        @(negedge clk);
        @(negedge clk);
        #4;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d exp 0", q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_sink.md
Name: regfile_writeback_sink

Overview:
- Integer register file that consumes the writeback-stage result bus (RegWriteW, RdW, ResultW) and serves the decode stage's two read ports.
- Provides same-cycle write-through bypass, so a value being written back is visible to decode in that cycle.
- Keeps a per-register pending-load scoreboard that raises a load-use stall to decode until the load's writeback lands.
- Sits between the WriteBack stage and the Decode stage; the hazard unit ORs StallLoadD into its stall/flush logic.

Parameters:
- XLEN, 32, data width of registers and result bus
- NREGS, 32, number of architectural registers; index 0 is hardwired zero
- AW, 5, register index width (log2 NREGS)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- RegWriteW  input  1  writeback write enable
- RdW  input  AW  writeback destination index
- ResultW  input  XLEN  writeback data
- A1D  input  AW  decode read port 1 index
- A2D  input  AW  decode read port 2 index
- RD1D  output  XLEN  read port 1 data
- RD2D  output  XLEN  read port 2 data
- LoadIssueE  input  1  a load is in Execute this cycle and will advance
- RdE  input  AW  destination index of that load
- StallLoadD  output  1  decode must stall (operand pending from an in-flight load)
- BusyVec  output  NREGS  scoreboard bits, for hazard unit and debug

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers clear to 0; all busy bits clear to 0.
  - Outputs follow combinationally: RD1D/RD2D=0, StallLoadD=0, BusyVec=0.
- Register write:
  - On rising clk, if RegWriteW=1 and RdW!=0, reg[RdW] <= ResultW.
  - Writes to index 0 are discarded; reg[0] always reads 0.
- Read ports (combinational, zero latency), per port p:
  - Ap=0 -> 0.
  - else if RegWriteW=1 and RdW=Ap -> ResultW (write-through bypass).
  - else -> reg[Ap].
- Scoreboard update, on rising clk, per bit i:
  - set if LoadIssueE=1 and RdE=i and i!=0.
  - else clear if RegWriteW=1 and RdW=i.
  - else hold.
  - Same-edge set and clear of the same index: set wins, because the new load is younger than the instruction retiring.
  - busy[0] is constant 0.
- Stall, combinational: StallLoadD=1 iff, for A1D or A2D, Ap!=0, busy[Ap]=1, and NOT (RegWriteW=1 and RdW=Ap).
  - A writeback landing this cycle satisfies the operand via bypass.
- Two reads of the same index, or A1D=A2D, behave identically on both ports.
- Reset asserted mid-operation:
  - state clears immediately, no clock needed.
  - Pending loads are forgotten; StallLoadD drops to 0 the same cycle.
- RegWriteW=1 with RdW=0 is a legal no-op: no write, no scoreboard effect, no bypass.
- No latency beyond one edge for writes; reads and stall are purely combinational from current inputs and state.

Test Plan:
- Reset then read: rst=0, release; A1D=5, A2D=31 -> RD1D=0, RD2D=0, StallLoadD=0, BusyVec=0.
- Write and bypass: RegWriteW=1, RdW=7, ResultW=0xDEADBEEF, A1D=7 in the same cycle -> RD1D=0xDEADBEEF before the edge. After the edge with RegWriteW=0 -> still 0xDEADBEEF.
- x0 immunity: RegWriteW=1, RdW=0, ResultW=0x12345678 -> A1D=0 reads 0 before and after the edge; BusyVec[0] stays 0 even with LoadIssueE=1, RdE=0.
- Load-use stall: LoadIssueE=1, RdE=3 at edge N -> BusyVec[3]=1; A2D=3 -> StallLoadD=1.
  - When RegWriteW=1, RdW=3, ResultW=0xA5A5A5A5 -> StallLoadD=0 and RD2D=0xA5A5A5A5 that cycle; BusyVec[3]=0 after the edge.
- Simultaneous set/clear: busy[9]=1; at one edge RegWriteW=1, RdW=9 and LoadIssueE=1, RdE=9 -> reg[9] updated, BusyVec[9] remains 1, StallLoadD=1 for A1D=9.
- Async reset mid-flight: busy[4]=1, reg[4]=0x55; drop rst between clock edges -> BusyVec=0, RD1D(A1D=4)=0, StallLoadD=0 immediately.
